// File: rtl/vga_fb_reader.sv
// vga_fb_reader: 640x480@60 VGA scan-out of an 8-bit grayscale framebuffer read one 32-bit word at a time
module vga_fb_reader #(
    parameter int          PIX_DIV   = 2,
    parameter int          READ_LAT  = 1,
    parameter int          IMG_W     = 256,
    parameter int          IMG_H     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bitVGA,
    output logic [31:0] address_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);
    localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;

    if (READ_LAT > PIX_DIV || PIX_DIV < 1 || IMG_W % 4 != 0 || IMG_W > 640 || IMG_H > 480) begin : g_bad_params
        $error("vga_fb_reader: illegal parameter combination");
    end

    logic [DW-1:0] div;
    logic          tick;
    logic [9:0]    h, v;
    logic          h_end, v_end;
    logic          in_img_c, vis_c, hs_c, vs_c;
    logic [31:0]   addr_c;
    logic          in1, vis1, hs1, vs1;
    logic [1:0]    sel1;
    logic [7:0]    pix;

    assign tick     = div == DW'(PIX_DIV - 1);
    assign h_end    = h == 10'd799;
    assign v_end    = v == 10'd524;
    assign in_img_c = h < 10'(IMG_W) && v < 10'(IMG_H);
    assign vis_c    = h < 10'd640 && v < 10'd480;
    assign hs_c     = !(h >= 10'd656 && h <= 10'd751);
    assign vs_c     = !(v >= 10'd490 && v <= 10'd491);
    assign addr_c   = in_img_c ? BASE_ADDR + 32'(v) * 32'(IMG_W / 4) + 32'(h[9:2]) : BASE_ADDR;
    assign vga_r    = pix;
    assign vga_g    = pix;
    assign vga_b    = pix;

    // pixel-tick divider: one tick every PIX_DIV clocks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) div <= '0;
        else      div <= tick ? '0 : div + 1'b1;
    end

    // stage 0: horizontal and vertical raster counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            h <= h_end ? '0 : h + 1'b1;
            if (h_end) v <= v_end ? '0 : v + 1'b1;
        end
    end

    // stage 1: issue the word address and carry timing flags alongside the pending read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            address_b   <= BASE_ADDR;
            in1         <= 1'b0;
            vis1        <= 1'b0;
            hs1         <= 1'b1;
            vs1         <= 1'b1;
            sel1        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && h == 10'd0 && v == 10'd0;
            if (tick) begin
                address_b <= addr_c;
                in1       <= in_img_c;
                vis1      <= vis_c;
                hs1       <= hs_c;
                vs1       <= vs_c;
                sel1      <= h[1:0];
            end
        end
    end

    // stage 2: pick the pixel byte from the returned word, aligned with sync and blank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            pix         <= '0;
        end else if (tick) begin
            vga_hs      <= hs1;
            vga_vs      <= vs1;
            vga_blank_n <= vis1;
            pix         <= vis1 && in1 ? bitVGA[{sel1, 3'b000} +: 8] : 8'h00;
        end
    end
endmodule
